// File: rtl/cpu_sequencer.sv
// Timing and instruction sequencer for the 6502 core: owns TCU and IR, injects
// BRK for reset/NMI/IRQ, and freezes instruction progress while RDY stalls a read.
module cpu_sequencer #(
    parameter int MAX_T = 7
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [7:0] i_data,
    input  logic [3:0] i_tcu_next,
    input  logic       i_rw,
    input  logic       i_rdy,
    input  logic       i_nmi_n,
    input  logic       i_irq_n,
    input  logic       i_p_i,
    output logic [7:0] o_ir,
    output logic [3:0] o_tcu,
    output logic       o_sync,
    output logic [1:0] o_int_type,
    output logic       o_int_inject,
    output logic       o_suppress_write,
    output logic [7:0] o_vector_lo,
    output logic       o_illegal
);

    localparam logic [3:0] MAX_TCU    = 4'(MAX_T);
    localparam logic [1:0] TYPE_OP    = 2'd0;
    localparam logic [1:0] TYPE_IRQ   = 2'd1;
    localparam logic [1:0] TYPE_NMI   = 2'd2;
    localparam logic [1:0] TYPE_RESET = 2'd3;

    logic [3:0] tcu, tcu_d;
    logic [7:0] ir, ir_d;
    logic [1:0] int_type, int_type_d;
    logic       nmi_latch, nmi_latch_d;
    logic       nmi_prev;
    logic       illegal, illegal_d;
    logic       stall, capture, nmi_fall;

    // RDY acts as a ready on read cycles only: a read with i_rdy low holds TCU,
    // IR and type; writes always complete regardless of i_rdy.
    always_comb begin
        stall    = ~i_rdy & i_rw;
        capture  = ~stall & (tcu == 4'd0);
        nmi_fall = nmi_prev & ~i_nmi_n;

        tcu_d       = tcu;
        ir_d        = ir;
        int_type_d  = int_type;
        nmi_latch_d = nmi_latch;
        illegal_d   = 1'b0;

        if (!stall) begin
            if (i_tcu_next > MAX_TCU) begin
                tcu_d     = 4'd0;
                illegal_d = 1'b1;
            end else begin
                tcu_d = i_tcu_next;
            end
        end

        if (capture) begin
            if (nmi_latch) begin
                ir_d        = 8'h00;
                int_type_d  = TYPE_NMI;
                nmi_latch_d = 1'b0;
            end else if (!i_irq_n && !i_p_i) begin
                ir_d       = 8'h00;
                int_type_d = TYPE_IRQ;
            end else begin
                ir_d       = i_data;
                int_type_d = TYPE_OP;
            end
        end

        // A new falling edge on the capture edge stays pending for the next T0.
        if (nmi_fall) begin
            nmi_latch_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            tcu       <= 4'd1;
            ir        <= 8'h00;
            int_type  <= TYPE_RESET;
            nmi_latch <= 1'b0;
            nmi_prev  <= 1'b1;
            illegal   <= 1'b0;
        end else begin
            tcu       <= tcu_d;
            ir        <= ir_d;
            int_type  <= int_type_d;
            nmi_latch <= nmi_latch_d;
            nmi_prev  <= i_nmi_n;
            illegal   <= illegal_d;
        end
    end

    always_comb begin
        case (int_type)
            TYPE_NMI:   o_vector_lo = 8'hFA;
            TYPE_RESET: o_vector_lo = 8'hFC;
            default:    o_vector_lo = 8'hFE;
        endcase
    end

    assign o_ir             = ir;
    assign o_tcu            = tcu;
    assign o_sync           = (tcu == 4'd0);
    assign o_int_type       = int_type;
    assign o_int_inject     = (int_type != TYPE_OP);
    assign o_suppress_write = (int_type == TYPE_RESET);
    assign o_illegal        = illegal;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: reset, opcode fetch, NMI/IRQ injection,
// RDY stalls, TCU overrun and asynchronous reset.
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] data;
    logic [3:0] tcu_next;
    logic       rw, rdy, nmi_n, irq_n, p_i;
    logic [7:0] ir;
    logic [3:0] tcu;
    logic       sync;
    logic [1:0] int_type;
    logic       int_inject, suppress_write, illegal;
    logic [7:0] vector_lo;

    int n_cmp = 0;
    int n_err = 0;

    cpu_sequencer #(.MAX_T(7)) dut (
        .i_clk            (clk),
        .i_reset_n        (reset_n),
        .i_data           (data),
        .i_tcu_next       (tcu_next),
        .i_rw             (rw),
        .i_rdy            (rdy),
        .i_nmi_n          (nmi_n),
        .i_irq_n          (irq_n),
        .i_p_i            (p_i),
        .o_ir             (ir),
        .o_tcu            (tcu),
        .o_sync           (sync),
        .o_int_type       (int_type),
        .o_int_inject     (int_inject),
        .o_suppress_write (suppress_write),
        .o_vector_lo      (vector_lo),
        .o_illegal        (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs already driven, outputs sampled 1 time unit after the edge.
    task automatic step(input logic [3:0] nxt, input logic [7:0] d);
        tcu_next = nxt;
        data     = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n  = 1'b0;
        data     = 8'h00;
        tcu_next = 4'd1;
        rw       = 1'b1;
        rdy      = 1'b1;
        nmi_n    = 1'b1;
        irq_n    = 1'b1;
        p_i      = 1'b1;

        // Reset held for three cycles
        repeat (3) @(posedge clk);
        #1;
        check("rst_tcu", 8'(tcu), 8'd1);
        check("rst_ir", ir, 8'h00);
        check("rst_type", 8'(int_type), 8'd3);
        check("rst_vec", vector_lo, 8'hFC);
        check("rst_sw", 8'(suppress_write), 8'd1);
        check("rst_sync", 8'(sync), 8'd0);
        check("rst_inject", 8'(int_inject), 8'd1);
        check("rst_illegal", 8'(illegal), 8'd0);
        reset_n = 1'b1;

        // Reset BRK sequence: TCU follows i_tcu_next with one cycle lag
        for (int t = 2; t <= 6; t++) begin
            step(4'(t), 8'h00);
            check("rst_seq_tcu", 8'(tcu), 8'(t));
            check("rst_seq_sw", 8'(suppress_write), 8'd1);
        end
        step(4'd0, 8'h00);
        check("rst_t0_tcu", 8'(tcu), 8'd0);
        check("rst_t0_sync", 8'(sync), 8'd1);
        check("rst_t0_type", 8'(int_type), 8'd3);

        // First opcode fetch
        step(4'd1, 8'hA9);
        check("fetch_ir", ir, 8'hA9);
        check("fetch_type", 8'(int_type), 8'd0);
        check("fetch_sw", 8'(suppress_write), 8'd0);
        check("fetch_inject", 8'(int_inject), 8'd0);
        check("fetch_vec", vector_lo, 8'hFE);
        check("fetch_sync", 8'(sync), 8'd0);

        // LDA immediate: sync 1, 0, 1
        step(4'd0, 8'h00);
        check("lda_sync0", 8'(sync), 8'd1);
        step(4'd1, 8'hA9);
        check("lda_sync1", 8'(sync), 8'd0);
        check("lda_ir", ir, 8'hA9);
        step(4'd0, 8'h00);
        check("lda_sync2", 8'(sync), 8'd1);

        // NMI dropped at T2 of a JMP-like sequence
        step(4'd1, 8'h4C);
        check("nmi_pre_ir", ir, 8'h4C);
        step(4'd2, 8'h00);
        nmi_n = 1'b0;
        step(4'd3, 8'h00);
        check("nmi_t3_tcu", 8'(tcu), 8'd3);
        check("nmi_t3_ir", ir, 8'h4C);
        nmi_n = 1'b1;
        step(4'd0, 8'h00);
        nmi_n = 1'b0;             // second falling edge on the capture edge
        step(4'd1, 8'h55);
        check("nmi_ir", ir, 8'h00);
        check("nmi_type", 8'(int_type), 8'd2);
        check("nmi_vec", vector_lo, 8'hFA);
        check("nmi_inject", 8'(int_inject), 8'd1);
        check("nmi_sw", 8'(suppress_write), 8'd0);
        nmi_n = 1'b1;
        step(4'd0, 8'h00);
        step(4'd1, 8'h55);
        check("nmi2_ir", ir, 8'h00);
        check("nmi2_type", 8'(int_type), 8'd2);
        step(4'd0, 8'h00);
        step(4'd1, 8'h55);
        check("nmi_clr_ir", ir, 8'h55);
        check("nmi_clr_type", 8'(int_type), 8'd0);

        // IRQ masked, then taken
        step(4'd0, 8'h00);
        irq_n = 1'b0;
        p_i   = 1'b1;
        step(4'd1, 8'hEA);
        check("irq_mask_ir", ir, 8'hEA);
        check("irq_mask_type", 8'(int_type), 8'd0);
        step(4'd0, 8'h00);
        p_i = 1'b0;
        step(4'd1, 8'hEA);
        check("irq_ir", ir, 8'h00);
        check("irq_type", 8'(int_type), 8'd1);
        check("irq_vec", vector_lo, 8'hFE);
        check("irq_inject", 8'(int_inject), 8'd1);
        irq_n = 1'b1;
        p_i   = 1'b1;

        // RDY stall on a read at T0
        step(4'd0, 8'h00);
        step(4'd1, 8'h11);
        check("rdy_pre_ir", ir, 8'h11);
        step(4'd0, 8'h00);
        rdy = 1'b0;
        rw  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(4'd3, 8'(8'h20 + i));
            check("stall_tcu", 8'(tcu), 8'd0);
            check("stall_ir", ir, 8'h11);
        end
        rdy = 1'b1;
        step(4'd1, 8'h22);
        check("unstall_ir", ir, 8'h22);
        check("unstall_tcu", 8'(tcu), 8'd1);

        // RDY ignored on write cycles
        rdy = 1'b0;
        rw  = 1'b0;
        step(4'd2, 8'h00);
        check("wr_tcu2", 8'(tcu), 8'd2);
        step(4'd3, 8'h00);
        check("wr_tcu3", 8'(tcu), 8'd3);
        rdy = 1'b1;
        rw  = 1'b1;

        // Overrun at T7, then an extreme request
        step(4'd7, 8'h00);
        check("ovr_t7", 8'(tcu), 8'd7);
        step(4'd8, 8'h00);
        check("ovr_tcu", 8'(tcu), 8'd0);
        check("ovr_illegal", 8'(illegal), 8'd1);
        step(4'd1, 8'h33);
        check("ovr_pulse_end", 8'(illegal), 8'd0);
        check("ovr_ir", ir, 8'h33);
        step(4'd15, 8'h00);
        check("ovr15_tcu", 8'(tcu), 8'd0);
        check("ovr15_illegal", 8'(illegal), 8'd1);
        step(4'd4, 8'h44);
        check("t4_tcu", 8'(tcu), 8'd4);
        check("t4_ir", ir, 8'h44);
        check("t4_illegal", 8'(illegal), 8'd0);

        // Asynchronous reset at T4, checked before the next edge
        #1;
        reset_n = 1'b0;
        #1;
        check("arst_tcu", 8'(tcu), 8'd1);
        check("arst_ir", ir, 8'h00);
        check("arst_type", 8'(int_type), 8'd3);
        check("arst_sw", 8'(suppress_write), 8'd1);
        check("arst_vec", vector_lo, 8'hFC);
        step(4'd5, 8'h00);
        check("arst_hold_tcu", 8'(tcu), 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
